cond_sum: RTL and testbench
===========================

COND_SUM -- requirements
Module: cond_sum

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width; legal values 16 (cond_sum16 configuration) and 32 (cond_sum32 configuration).
REQ-002 Parameter BLK, default 4, leaf conditional-sum block width; WIDTH SHALL be a power-of-two multiple of BLK.
REQ-003 Port clk  input  1  single clock; all registered state on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port A  input  WIDTH  addend A, unsigned/two's-complement agnostic.
REQ-006 Port B  input  WIDTH  addend B.
REQ-007 Port CIN  input  1  carry-in.
REQ-008 Port S  output  WIDTH  combinational sum (A+B+CIN) mod 2^WIDTH.
REQ-009 Port COUT  output  1  combinational carry-out, bit WIDTH of A+B+CIN.
REQ-010 Port S_R  output  WIDTH  registered copy of S.
REQ-011 Port COUT_R  output  1  registered copy of COUT.

Function
REQ-012 S and COUT SHALL be purely combinational from A, B, CIN: zero-cycle latency, no dependence on clk or rst.
REQ-013 {COUT,S} SHALL equal the exact (WIDTH+1)-bit sum A+B+CIN for every input combination.
REQ-014 Adder SHALL use conditional-sum architecture: each BLK-bit leaf computes sum and carry for both carry-in 0 and 1; adjacent halves merge by selecting the upper half's pair with the lower half's carries, recursively, up to WIDTH.
REQ-015 Final S/COUT SHALL be selected from the top-level 0/1 pair by CIN; no ripple chain longer than BLK bits.
REQ-016 On each rising clk edge with rst=0, S_R<=S and COUT_R<=COUT (latency exactly 1 cycle, updated every cycle, no enable).
REQ-017 Overflow/signed saturation is out of scope; carries past bit WIDTH are reported only on COUT.
REQ-018 Wrap-around: all-ones + 1 SHALL give S=0, COUT=1; all-ones + all-ones + 1 SHALL give S=all-ones, COUT=1.
REQ-019 X/Z-free inputs SHALL yield X-free outputs; no latches.

Reset
REQ-020 When rst=1 at a rising clk edge, S_R<=0 and COUT_R<=0; rst has priority over the data update.
REQ-021 rst SHALL NOT affect S or COUT; combinational outputs remain valid during reset.
REQ-022 Release of rst SHALL resume capture on the first subsequent edge with rst=0.

Structure
REQ-023 No shared package required; WIDTH and BLK are local parameters of the module.
REQ-024 One sub-module cond_sum_blk (BLK-bit dual-carry leaf: outputs s0,c0 for cin=0 and s1,c1 for cin=1), instantiated WIDTH/BLK times via generate.
REQ-025 Merge tree and output register SHALL live in cond_sum; cond_sum16/cond_sum32 SHALL be thin wrappers fixing WIDTH and tying off S_R/COUT_R use as needed.

Verification
REQ-026 WIDTH=16: A=16'hFFFF, B=16'h0001, CIN=0 -> S=16'h0000, COUT=1; next edge S_R=16'h0000, COUT_R=1.
REQ-027 WIDTH=16: A=16'h7FFF, B=16'h0000, CIN=1 -> S=16'h8000, COUT=0 (carry crosses every block boundary).
REQ-028 WIDTH=32 decrement: A=32'h00000005, B=32'hFFFFFFFF, CIN=0 -> S=32'h00000004, COUT=1; A=0, same B -> S=32'hFFFFFFFF, COUT=0.
REQ-029 WIDTH=32: A=B=32'hFFFFFFFF, CIN=1 -> S=32'hFFFFFFFF, COUT=1.
REQ-030 Reset: load A=16'h1234,B=16'h1111 for one cycle (S_R=16'h2345), assert rst one edge -> S_R=0, COUT_R=0 while S still 16'h2345; deassert -> S_R=16'h2345 next edge.
REQ-031 Random: 10^5 vectors per WIDTH, compare {COUT,S} to A+B+CIN combinationally and {COUT_R,S_R} to previous-cycle value.

Source files
------------

// File: rtl/cond_sum_pkg.sv
// Shared parameters and helpers for the conditional-sum adder.
// Carry vectors of all merge levels are packed end to end.
package cond_sum_pkg;

  localparam int CS_WIDTH = 16;
  localparam int CS_BLK   = 4;

  // Base index of level l carries when level 0 holds nb entries.
  function automatic int c_off(input int nb, input int l);
    return 2 * nb - ((2 * nb) >> l);
  endfunction

endpackage

// File: rtl/cond_sum_blk.sv
// Dual-carry leaf: BLK-bit sums for carry-in 0 and carry-in 1.
// Each leaf ripples at most BLK bits.
module cond_sum_blk #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] s0,
  output logic           c0,
  output logic [BLK-1:0] s1,
  output logic           c1
);

  logic [BLK:0] ext_a;
  logic [BLK:0] ext_b;

  assign ext_a = {1'b0, a};
  assign ext_b = {1'b0, b};

  // Both candidate results, one per assumed carry-in.
  always_comb begin
    {c0, s0} = ext_a + ext_b;
    {c1, s1} = ext_a + ext_b + (BLK+1)'(1);
  end

endmodule

// File: rtl/cond_sum_cfg.sv
// Fixed-width configurations of the conditional-sum adder.
// Both are straight pass-throughs with WIDTH pinned.
module cond_sum16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CIN,
  output logic [15:0] S,
  output logic        COUT,
  output logic [15:0] S_R,
  output logic        COUT_R
);

  cond_sum #(
    .WIDTH(16),
    .BLK  (4)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .CIN    (CIN),
    .S      (S),
    .COUT   (COUT),
    .S_R    (S_R),
    .COUT_R (COUT_R)
  );

endmodule

module cond_sum32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        CIN,
  output logic [31:0] S,
  output logic        COUT,
  output logic [31:0] S_R,
  output logic        COUT_R
);

  cond_sum #(
    .WIDTH(32),
    .BLK  (4)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .CIN    (CIN),
    .S      (S),
    .COUT   (COUT),
    .S_R    (S_R),
    .COUT_R (COUT_R)
  );

endmodule

// File: rtl/cond_sum.sv
// Conditional-sum adder: dual-carry leaves, log2 merge tree,
// final carry-in select and a one-cycle output register.
module cond_sum
  import cond_sum_pkg::*;
#(
  parameter int WIDTH = CS_WIDTH,
  parameter int BLK   = CS_BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic [WIDTH-1:0] S_R,
  output logic             COUT_R
);

  localparam int NB   = WIDTH / BLK;
  localparam int LVLS = $clog2(NB);
  localparam int NC   = 2 * NB - 1;

  logic [WIDTH-1:0] s0_t [LVLS+1];
  logic [WIDTH-1:0] s1_t [LVLS+1];
  logic [NC-1:0]    c0_t;
  logic [NC-1:0]    c1_t;

  for (genvar j = 0; j < NB; j++) begin : g_leaf
    cond_sum_blk #(
      .BLK(BLK)
    ) u_blk (
      .a  (A[j*BLK +: BLK]),
      .b  (B[j*BLK +: BLK]),
      .s0 (s0_t[0][j*BLK +: BLK]),
      .c0 (c0_t[j]),
      .s1 (s1_t[0][j*BLK +: BLK]),
      .c1 (c1_t[j])
    );
  end

  for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
    localparam int N  = NB >> l;
    localparam int G  = BLK << l;
    localparam int H  = G / 2;
    localparam int CO = c_off(NB, l);
    localparam int PO = c_off(NB, l - 1);

    for (genvar j = 0; j < N; j++) begin : g_grp
      logic         cl0;
      logic         cl1;
      logic         cu0;
      logic         cu1;
      logic [H-1:0] su0;
      logic [H-1:0] su1;

      assign cl0 = c0_t[PO + 2*j];
      assign cl1 = c1_t[PO + 2*j];
      assign cu0 = c0_t[PO + 2*j + 1];
      assign cu1 = c1_t[PO + 2*j + 1];
      assign su0 = s0_t[l-1][(2*j+1)*H +: H];
      assign su1 = s1_t[l-1][(2*j+1)*H +: H];

      assign s0_t[l][j*G +: H]     = s0_t[l-1][2*j*H +: H];
      assign s0_t[l][j*G + H +: H] = cl0 ? su1 : su0;
      assign c0_t[CO + j]          = cl0 ? cu1 : cu0;

      assign s1_t[l][j*G +: H]     = s1_t[l-1][2*j*H +: H];
      assign s1_t[l][j*G + H +: H] = cl1 ? su1 : su0;
      assign c1_t[CO + j]          = cl1 ? cu1 : cu0;
    end
  end

  // Real carry-in picks the top-level candidate pair.
  always_comb begin
    S    = CIN ? s1_t[LVLS] : s0_t[LVLS];
    COUT = CIN ? c1_t[NC-1] : c0_t[NC-1];
  end

  // Capture the sum every cycle; reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      S_R    <= '0;
      COUT_R <= 1'b0;
    end else begin
      S_R    <= S;
      COUT_R <= COUT;
    end
  end

endmodule

// File: tb/tb_cond_sum.sv
// Directed and small random checks for cond_sum at 16 and 32 bits.
// Combinational outputs checked after drive, registered after edge.
module tb_cond_sum;

  logic        clk;
  logic        rst;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin16;
  logic [15:0] s16;
  logic        cout16;
  logic [15:0] sr16;
  logic        coutr16;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        cin32;
  logic [31:0] s32;
  logic        cout32;
  logic [31:0] sr32;
  logic        coutr32;

  int checks;
  int errors;

  cond_sum #(
    .WIDTH(16),
    .BLK  (4)
  ) u16 (
    .clk    (clk),
    .rst    (rst),
    .A      (a16),
    .B      (b16),
    .CIN    (cin16),
    .S      (s16),
    .COUT   (cout16),
    .S_R    (sr16),
    .COUT_R (coutr16)
  );

  cond_sum #(
    .WIDTH(32),
    .BLK  (4)
  ) u32 (
    .clk    (clk),
    .rst    (rst),
    .A      (a32),
    .B      (b32),
    .CIN    (cin32),
    .S      (s32),
    .COUT   (cout32),
    .S_R    (sr32),
    .COUT_R (coutr32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [32:0] got,
                     input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic run16(input string tag,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic        c,
                       input logic [16:0] exp);
    @(negedge clk);
    a16 = a;
    b16 = b;
    cin16 = c;
    #1;
    chk({tag, "_c"}, {16'd0, cout16, s16}, {16'd0, exp});
    @(posedge clk);
    #1;
    chk({tag, "_r"}, {16'd0, coutr16, sr16}, {16'd0, exp});
  endtask

  task automatic run32(input string tag,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic        c,
                       input logic [32:0] exp);
    @(negedge clk);
    a32 = a;
    b32 = b;
    cin32 = c;
    #1;
    chk({tag, "_c"}, {cout32, s32}, exp);
    @(posedge clk);
    #1;
    chk({tag, "_r"}, {coutr32, sr32}, exp);
  endtask

  initial begin
    logic [16:0] e16;
    logic [32:0] e32;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a16 = 16'h0003;
    b16 = 16'h0004;
    cin16 = 1'b0;
    a32 = 32'h0000_0010;
    b32 = 32'h0000_0020;
    cin32 = 1'b1;

    @(posedge clk);
    #1;
    chk("rst16_r", {16'd0, coutr16, sr16}, 33'd0);
    chk("rst32_r", {coutr32, sr32}, 33'd0);
    chk("rst16_c", {16'd0, cout16, s16}, 33'h0_0007);
    chk("rst32_c", {cout32, s32}, 33'h0_0000_0031);
    @(negedge clk);
    rst = 1'b0;

    run16("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 17'h1_0000);
    run16("7fff_ci", 16'h7FFF, 16'h0000, 1'b1, 17'h0_8000);
    run16("ones_ci", 16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF);
    run16("ffff_ci", 16'hFFFF, 16'h0000, 1'b1, 17'h1_0000);
    run16("zero",    16'h0000, 16'h0000, 1'b0, 17'h0_0000);
    run16("00ff_p1", 16'h00FF, 16'h0001, 1'b0, 17'h0_0100);
    run16("msb_msb", 16'h8000, 16'h8000, 1'b0, 17'h1_0000);
    run16("mix",     16'hA5A5, 16'h5A5A, 1'b1, 17'h1_0000);

    run32("dec5",    32'h0000_0005, 32'hFFFF_FFFF, 1'b0,
          33'h1_0000_0004);
    run32("dec0",    32'h0000_0000, 32'hFFFF_FFFF, 1'b0,
          33'h0_FFFF_FFFF);
    run32("ones_ci", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
          33'h1_FFFF_FFFF);
    run32("0fff_p1", 32'h0FFF_FFFF, 32'h0000_0001, 1'b0,
          33'h0_1000_0000);
    run32("mix",     32'h1234_5678, 32'h8765_4321, 1'b0,
          33'h0_9999_9999);

    // Reset clears the register but not the combinational sum.
    @(negedge clk);
    a16 = 16'h1234;
    b16 = 16'h1111;
    cin16 = 1'b0;
    @(posedge clk);
    #1;
    chk("rld_load", {16'd0, coutr16, sr16}, 33'h0_2345);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rld_sr",  {16'd0, coutr16, sr16}, 33'd0);
    chk("rld_s",   {16'd0, cout16, s16}, 33'h0_2345);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rld_rel", {16'd0, coutr16, sr16}, 33'h0_2345);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      cin16 = 1'($urandom);
      a32 = $urandom;
      b32 = $urandom;
      cin32 = 1'($urandom);
      e16 = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
      e32 = {1'b0, a32} + {1'b0, b32} + {32'd0, cin32};
      #1;
      chk("rnd16_c", {16'd0, cout16, s16}, {16'd0, e16});
      chk("rnd32_c", {cout32, s32}, e32);
      @(posedge clk);
      #1;
      chk("rnd16_r", {16'd0, coutr16, sr16}, {16'd0, e16});
      chk("rnd32_r", {coutr32, sr32}, e32);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
